// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs ARM-subset instruction fields into 32-bit machine words and writes
//   them to consecutive instruction-memory word addresses starting at BASE.
//   Bundles the core's decoder cannot execute are rejected and flagged.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             pulse: (re)start a program at BASE
//   in_valid/in_ready field-bundle handshake (ready only while running)
//   op,funct,cond,rn,rd,imm  instruction fields
//   we,waddr,wdata    registered instruction-memory write port
//   count             words written since start
//   full              last memory address has been written
//   err, err_addr     sticky reject flag, address of the first rejected bundle
module instr_encoder #(
   parameter int          ADDR_W = 6,
   parameter int unsigned BASE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        op,
   input  logic [5:0]        funct,
   input  logic [3:0]        cond,
   input  logic [3:0]        rn,
   input  logic [3:0]        rd,
   input  logic [23:0]       imm,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr
);

   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

   typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;     // address the next legal bundle will use
   logic [31:0]       enc;
   logic              legal;
   logic              accept;

   assign in_ready = (state == RUN);
   assign accept   = in_valid && in_ready;

   // Encoding and legality check on the presented bundle.
   always_comb begin
      enc   = '0;
      legal = 1'b0;
      case (op)
         2'b00: begin
            enc   = {cond, 2'b00, funct, rn, rd, imm[11:0]};
            // only ADD, SUB, AND, ORR are executed by the core
            legal = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010) ||
                    (funct[4:1] == 4'b0000) || (funct[4:1] == 4'b1100);
         end
         2'b01: begin
            enc   = {cond, 2'b01, funct, rn, rd, imm[11:0]};
            // immediate offset (funct[5] is ~I) and word access only
            legal = !funct[5] && !funct[2];
         end
         2'b10: begin
            enc   = {cond, 2'b10, funct[5:4], imm};
            legal = (funct[5:4] == 2'b10);   // plain B, no link
         end
         default: begin
            enc   = '0;
            legal = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         addr     <= BASE_A;
         we       <= 1'b0;
         waddr    <= '0;
         wdata    <= '0;
         count    <= '0;
         full     <= 1'b0;
         err      <= 1'b0;
         err_addr <= '0;
      end else begin
         we <= 1'b0;
         // start has priority: a bundle offered alongside it is dropped
         if (start) begin
            state    <= RUN;
            addr     <= BASE_A;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
            err_addr <= '0;
         end else if (accept) begin
            if (legal) begin
               we    <= 1'b1;
               waddr <= addr;
               wdata <= enc;
               count <= count + 1'b1;
               // no wrap: the top address ends the program
               if (addr == '1) begin
                  full  <= 1'b1;
                  state <= FULL;
               end else begin
                  addr <= addr + 1'b1;
               end
            end else begin
               err <= 1'b1;
               if (!err) err_addr <= addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench: two encoders (ADDR_W=6 and ADDR_W=2) share one stimulus
// stream; a reference model predicts writes and status per instance.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic [3:0]  cond, rn, rd;
   logic [23:0] imm;

   logic        rdy6, we6, full6, err6;
   logic [5:0]  waddr6, eaddr6;
   logic [31:0] wdata6;
   logic [6:0]  count6;
   logic        rdy2, we2, full2, err2;
   logic [1:0]  waddr2, eaddr2;
   logic [31:0] wdata2;
   logic [2:0]  count2;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(6), .BASE(0)) dut6 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy6),
      .op(op), .funct(funct), .cond(cond), .rn(rn), .rd(rd), .imm(imm),
      .we(we6), .waddr(waddr6), .wdata(wdata6), .count(count6), .full(full6),
      .err(err6), .err_addr(eaddr6));

   instr_encoder #(.ADDR_W(2), .BASE(0)) dut2 (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy2),
      .op(op), .funct(funct), .cond(cond), .rn(rn), .rd(rd), .imm(imm),
      .we(we2), .waddr(waddr2), .wdata(wdata2), .count(count2), .full(full2),
      .err(err2), .err_addr(eaddr2));

   // actual outputs gathered per instance
   logic        a_rdy[2], a_we[2], a_full[2], a_err[2];
   logic [31:0] a_waddr[2], a_wdata[2], a_cnt[2], a_eaddr[2];
   assign a_rdy[0] = rdy6;   assign a_rdy[1] = rdy2;
   assign a_we[0]  = we6;    assign a_we[1]  = we2;
   assign a_full[0] = full6; assign a_full[1] = full2;
   assign a_err[0] = err6;   assign a_err[1] = err2;
   assign a_waddr[0] = 32'(waddr6); assign a_waddr[1] = 32'(waddr2);
   assign a_wdata[0] = wdata6;      assign a_wdata[1] = wdata2;
   assign a_cnt[0]   = 32'(count6); assign a_cnt[1]   = 32'(count2);
   assign a_eaddr[0] = 32'(eaddr6); assign a_eaddr[1] = 32'(eaddr2);

   // ---------------- reference model ----------------
   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;
   wr_t q0[$];
   wr_t q1[$];

   int depth[2] = '{64, 4};
   int m_st[2];        // 0 idle, 1 running, 2 memory full
   int m_addr[2], m_cnt[2], m_eaddr[2];
   bit m_full[2], m_err[2];
   bit m_rst  = 1'b0;
   bit armed  = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   function automatic bit ref_legal(input logic [1:0] o, input logic [5:0] f);
      int cmd;
      cmd = int'(f[4:1]);
      case (o)
         2'd0:    return (cmd == 4) || (cmd == 2) || (cmd == 0) || (cmd == 12);
         2'd1:    return (f[5] == 1'b0) && (f[2] == 1'b0);
         2'd2:    return f[5:4] == 2'b10;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_word(input logic [1:0] o, input logic [5:0] f,
                                            input logic [3:0] c, input logic [3:0] n,
                                            input logic [3:0] d, input logic [23:0] im);
      logic [31:0] w;
      w = (32'(c) << 28) | (32'(o) << 26);
      if (o == 2'd2) w = w | (32'(f[5:4]) << 24) | 32'(im);
      else           w = w | (32'(f) << 20) | (32'(n) << 16) | (32'(d) << 12) | 32'(im[11:0]);
      return w;
   endfunction

   // advance the model by one clock edge for the inputs being applied
   task automatic model_step(input bit rs, input bit st, input bit v,
                             input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                             input logic [3:0] n, input logic [3:0] d, input logic [23:0] im);
      wr_t e;
      m_rst = rs;
      for (int k = 0; k < 2; k++) begin
         if (rs || st) begin
            m_st[k] = rs ? 0 : 1;
            m_addr[k] = 0; m_cnt[k] = 0; m_full[k] = 1'b0;
            m_err[k] = 1'b0; m_eaddr[k] = 0;
         end else if (m_st[k] == 1 && v) begin
            if (ref_legal(o, f)) begin
               e.addr = m_addr[k];
               e.data = ref_word(o, f, c, n, d, im);
               if (k == 0) q0.push_back(e); else q1.push_back(e);
               m_cnt[k]++;
               if (m_addr[k] == depth[k] - 1) begin
                  m_full[k] = 1'b1;
                  m_st[k] = 2;
               end else begin
                  m_addr[k]++;
               end
            end else begin
               if (!m_err[k]) m_eaddr[k] = m_addr[k];
               m_err[k] = 1'b1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[aw%0d] @%0t: got %h expected %h", name, (k == 0) ? 6 : 2, $time, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      wr_t e;
      bit  have;
      if (armed) begin
         for (int k = 0; k < 2; k++) begin
            chk("in_ready", k, 32'(a_rdy[k]), 32'(m_st[k] == 1));
            chk("count",    k, a_cnt[k],      32'(m_cnt[k]));
            chk("full",     k, 32'(a_full[k]), 32'(m_full[k]));
            chk("err",      k, 32'(a_err[k]),  32'(m_err[k]));
            chk("err_addr", k, a_eaddr[k],    32'(m_eaddr[k]));
            have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (have) e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("we", k, 32'(a_we[k]), 32'(have));
            if (have && a_we[k] === 1'b1) begin
               chk("waddr", k, a_waddr[k], 32'(e.addr));
               chk("wdata", k, a_wdata[k], e.data);
            end
            if (m_rst) begin
               chk("rst_waddr", k, a_waddr[k], 32'd0);
               chk("rst_wdata", k, a_wdata[k], 32'd0);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic cyc(input bit rs, input bit st, input bit v,
                      input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                      input logic [3:0] n, input logic [3:0] d, input logic [23:0] im);
      @(negedge clk);
      #1;
      reset = rs; start = st; in_valid = v;
      op = o; funct = f; cond = c; rn = n; rd = d; imm = im;
      model_step(rs, st, v, o, f, c, n, d, im);
      if (rs) armed = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'd0, 6'd0, 4'd0, 4'd0, 4'd0, 24'd0);
   endtask

   task automatic strt();
      cyc(0, 1, 0, 2'd0, 6'd0, 4'd0, 4'd0, 4'd0, 24'd0);
   endtask

   task automatic bnd(input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                      input logic [3:0] n, input logic [3:0] d, input logic [23:0] im);
      cyc(0, 0, 1, o, f, c, n, d, im);
   endtask

   task automatic add_b();
      bnd(2'b00, 6'b101000, 4'hE, 4'd1, 4'd2, 24'h5);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0;
      op = '0; funct = '0; cond = '0; rn = '0; rd = '0; imm = '0;

      cyc(1, 0, 0, 2'd0, 6'd0, 4'd0, 4'd0, 4'd0, 24'd0);
      cyc(1, 0, 0, 2'd0, 6'd0, 4'd0, 4'd0, 4'd0, 24'd0);
      idle(1);
      add_b();                            // ignored while idle

      // single ADD
      strt(); add_b(); idle(1);

      // ADD, LDR, B back-to-back
      strt(); add_b();
      bnd(2'b01, 6'b011001, 4'hE, 4'd0, 4'd3, 24'h4);
      bnd(2'b10, 6'b100000, 4'hE, 4'd0, 4'd0, 24'hFFFFFE);
      idle(1);

      // illegal DP in the middle, then a second illegal
      strt(); add_b();
      bnd(2'b00, 6'b111010, 4'hE, 4'd1, 4'd2, 24'h7);
      add_b();
      bnd(2'b00, 6'b111010, 4'hE, 4'd1, 4'd2, 24'h7);
      idle(1);

      // five legal bundles: the 4-deep instance fills and refuses the fifth
      strt();
      for (int i = 0; i < 5; i++) bnd(2'b00, 6'b001000, 4'h0, 4'(i), 4'(i + 1), 24'(i * 3));
      idle(1);
      strt(); add_b(); idle(1);

      // op=11 and branch-with-link are rejected
      strt();
      bnd(2'b11, 6'b000000, 4'hE, 4'd1, 4'd2, 24'h1);
      bnd(2'b10, 6'b110000, 4'hE, 4'd0, 4'd0, 24'h10);
      idle(1);

      // reset right after an acceptance, and reset together with a bundle
      strt(); add_b();
      cyc(1, 0, 1, 2'b00, 6'b101000, 4'hE, 4'd1, 4'd2, 24'h5);
      idle(1); add_b();
      strt(); add_b();
      cyc(1, 0, 1, 2'b00, 6'b101000, 4'hE, 4'd3, 4'd4, 24'h6);
      idle(1);

      // start with a bundle in the same cycle, while running
      strt(); add_b();
      cyc(0, 1, 1, 2'b00, 6'b101000, 4'hE, 4'd1, 4'd2, 24'h9);
      add_b(); idle(1);

      // random traffic, legal-biased so the 64-deep instance also fills
      strt();
      for (int i = 0; i < 400; i++) begin
         logic [1:0] o;
         logic [5:0] f;
         bit rs, st, v;
         rs = ($urandom_range(0, 199) == 0);
         st = ($urandom_range(0, 59) == 0);
         v  = ($urandom_range(0, 3) != 0);
         o  = 2'($urandom_range(0, 3));
         f  = 6'($urandom);
         if ($urandom_range(0, 2) != 0) begin
            case (o)
               2'd0: f[4:1] = 4'b0100;
               2'd1: begin f[5] = 1'b0; f[2] = 1'b0; end
               2'd2: f[5:4] = 2'b10;
               default: o = 2'd1;
            endcase
            if (o == 2'd1) begin f[5] = 1'b0; f[2] = 1'b0; end
         end
         cyc(rs, st, v, o, f, 4'($urandom), 4'($urandom), 4'($urandom), 24'($urandom));
         if (rs) strt();
      end
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
